// File: rtl/regfile_bank_ctrl.sv
// regfile_bank_ctrl
//   Parametrised register file with byte-lane writes and NRD registered read
//   ports. It has an optional write-to-read bypass and an optional
//   hardwired-zero entry 0. It also contains a multi-cycle bulk-clear engine
//   and a valid/ready scan streamer that walks every entry in address order.
//
// Ports
//   clk, reset                 clock; synchronous active-high reset
//   wen, waddr, wdata          byte-lane write (bit i -> wdata[8i+7:8i])
//   rden, raddr, rdata         per-port read enable/address; 1-cycle read data
//   clear_req, clear_busy      start bulk clear; high for DEPTH cycles
//   scan_start                 start a scan of all entries
//   scan_valid, scan_ready     scan beat handshake
//   scan_addr, scan_data       current beat address and entry content
//   scan_done                  one-cycle pulse after the last beat is accepted
module regfile_bank_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NRD     = 2,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W/8-1:0]   wen,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [NRD-1:0]        rden,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    input  logic                  clear_req,
    output logic                  clear_busy,
    input  logic                  scan_start,
    output logic                  scan_valid,
    input  logic                  scan_ready,
    output logic [ADDR_W-1:0]     scan_addr,
    output logic [DATA_W-1:0]     scan_data,
    output logic                  scan_done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic {C_IDLE, C_RUN} clr_state_t;
    typedef enum logic {S_IDLE, S_RUN} scan_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    clr_state_t        c_state;
    logic [ADDR_W-1:0] c_cnt;
    scan_state_t       s_state;

    logic [DATA_W-1:0] wmask;
    logic              wr_ok;

    // Expand byte-lane enables into a bit mask.
    always_comb begin
        wmask = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            wmask[8*i +: 8] = {8{wen[i]}};
        end
    end

    // A write is accepted only outside the clear engine, not when a clear
    // starts this cycle, and never to the hardwired-zero entry.
    assign wr_ok = (|wen) && (c_state == C_IDLE) && !clear_req &&
                   !((ZERO_R0 != 0) && (waddr == '0));

    // Storage: reset > clear engine > normal write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[ADDR_W'(i)] <= '0;
            end
        end else if (c_state == C_RUN) begin
            mem[c_cnt] <= '0;
        end else if (wr_ok) begin
            mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask);
        end
    end

    // Registered read ports
    logic [DATA_W-1:0] rd_q [NRD];

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd_next;

        assign ra = raddr[k*ADDR_W +: ADDR_W];

        // The bypass merges only the enabled lanes of an accepted write.
        // Disabled lanes keep the old bytes.
        always_comb begin
            rd_next = mem[ra];
            if ((BYPASS != 0) && wr_ok && (waddr == ra)) begin
                rd_next = (mem[ra] & ~wmask) | (wdata & wmask);
            end
            if ((ZERO_R0 != 0) && (ra == '0)) begin
                rd_next = '0;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                rd_q[k] <= '0;
            end else if (rden[k]) begin
                rd_q[k] <= rd_next;
            end
        end

        assign rdata[k*DATA_W +: DATA_W] = rd_q[k];
    end

    // Clear engine: writes 0 to each entry in turn, taking DEPTH cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            c_state <= C_IDLE;
            c_cnt   <= '0;
        end else begin
            case (c_state)
                C_IDLE: begin
                    if (clear_req) begin
                        c_state <= C_RUN;
                        c_cnt   <= '0;
                    end
                end
                C_RUN: begin
                    c_cnt <= c_cnt + 1'b1;
                    if (c_cnt == '1) begin
                        c_state <= C_IDLE;
                    end
                end
                default: c_state <= C_IDLE;
            endcase
        end
    end

    assign clear_busy = (c_state == C_RUN);

    // Scan streamer. A clear request aborts a running scan without scan_done.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_state   <= S_IDLE;
            scan_addr <= '0;
            scan_done <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            case (s_state)
                S_IDLE: begin
                    if (scan_start && (c_state == C_IDLE) && !clear_req) begin
                        s_state   <= S_RUN;
                        scan_addr <= '0;
                    end
                end
                S_RUN: begin
                    if (clear_req) begin
                        s_state   <= S_IDLE;
                        scan_addr <= '0;
                    end else if (scan_ready) begin
                        if (scan_addr == '1) begin
                            s_state   <= S_IDLE;
                            scan_addr <= '0;
                            scan_done <= 1'b1;
                        end else begin
                            scan_addr <= scan_addr + 1'b1;
                        end
                    end
                end
                default: s_state <= S_IDLE;
            endcase
        end
    end

    assign scan_valid = (s_state == S_RUN);
    assign scan_data  = ((ZERO_R0 != 0) && (scan_addr == '0)) ? '0 : mem[scan_addr];

endmodule

// File: tb/tb_regfile_bank_ctrl.sv
module tb_regfile_bank_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  rden;
    logic [9:0]  raddr;
    logic [63:0] rdata, nb_rdata;
    logic        clear_req, clear_busy, nb_clear_busy;
    logic        scan_start, scan_valid, nb_scan_valid, scan_ready;
    logic [4:0]  scan_addr, nb_scan_addr;
    logic [31:0] scan_data, nb_scan_data;
    logic        scan_done, nb_scan_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_bank_ctrl #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_R0(1), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .wen(wen), .waddr(waddr), .wdata(wdata),
        .rden(rden), .raddr(raddr), .rdata(rdata),
        .clear_req(clear_req), .clear_busy(clear_busy),
        .scan_start(scan_start), .scan_valid(scan_valid), .scan_ready(scan_ready),
        .scan_addr(scan_addr), .scan_data(scan_data), .scan_done(scan_done)
    );

    // Same stimulus, no bypass: reads return pre-write content.
    regfile_bank_ctrl #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_R0(1), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .wen(wen), .waddr(waddr), .wdata(wdata),
        .rden(rden), .raddr(raddr), .rdata(nb_rdata),
        .clear_req(clear_req), .clear_busy(nb_clear_busy),
        .scan_start(scan_start), .scan_valid(nb_scan_valid), .scan_ready(scan_ready),
        .scan_addr(nb_scan_addr), .scan_data(nb_scan_data), .scan_done(nb_scan_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int beats;
        int cyc;
        logic done_seen;

        reset = 1'b1; wen = '0; waddr = '0; wdata = '0; rden = '0; raddr = '0;
        clear_req = 1'b0; scan_start = 1'b0; scan_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        chk("rst_rdata0", rdata[31:0], 32'h0);
        chk("rst_rdata1", rdata[63:32], 32'h0);
        chk("rst_busy", {31'b0, clear_busy}, 32'h0);
        chk("rst_valid", {31'b0, scan_valid}, 32'h0);
        chk("rst_saddr", {27'b0, scan_addr}, 32'h0);
        chk("rst_done", {31'b0, scan_done}, 32'h0);

        // 1: full write, then a partial byte-lane write
        waddr = 5'd3; wdata = 32'h12345678; wen = 4'hF; step();
        wen = '0; rden = 2'b01; raddr[4:0] = 5'd3; step();
        chk("rd_full", rdata[31:0], 32'h12345678);
        rden = '0; waddr = 5'd3; wdata = 32'hAABBCCDD; wen = 4'b0101; step();
        wen = '0; rden = 2'b01; step();
        chk("rd_lanes", rdata[31:0], 32'h12BB56DD);

        // 2: bypass vs no bypass, then hold with rden=0
        rden = 2'b10; raddr[9:5] = 5'd7; waddr = 5'd7; wdata = 32'hDEADBEEF; wen = 4'hF; step();
        chk("byp_on", rdata[63:32], 32'hDEADBEEF);
        chk("byp_off", nb_rdata[63:32], 32'h0);
        wen = '0; rden = 2'b00; raddr[9:5] = 5'd3; step();
        chk("rd_hold", rdata[63:32], 32'hDEADBEEF);
        chk("rd_hold_nb", nb_rdata[63:32], 32'h0);
        rden = 2'b10; raddr[9:5] = 5'd7; waddr = 5'd7; wdata = 32'h11223344; wen = 4'b0011; step();
        chk("byp_part", rdata[63:32], 32'hDEAD3344);
        chk("byp_part_nb", nb_rdata[63:32], 32'hDEADBEEF);
        wen = '0; step();
        chk("rd_after_part", nb_rdata[63:32], 32'hDEAD3344);

        // 3: entry 0 is hardwired zero
        rden = '0; waddr = 5'd0; wdata = 32'hFFFFFFFF; wen = 4'hF; step();
        wen = '0; rden = 2'b01; raddr[4:0] = 5'd0; step();
        chk("zero_r0", rdata[31:0], 32'h0);

        // 4: fill, clear with writes issued during busy, verify all zero
        rden = '0;
        for (int a = 0; a < 32; a++) begin
            waddr = 5'(a); wdata = 32'(a) * 32'h11111111; wen = 4'hF; step();
        end
        wen = '0; rden = 2'b01; raddr[4:0] = 5'd5; step();
        chk("fill5", rdata[31:0], 32'h55555555);
        clear_req = 1'b1; waddr = 5'd9; wdata = 32'hFFFFFFFF; wen = 4'hF; step();
        clear_req = 1'b0;
        n = 0;
        waddr = 5'd3; wdata = 32'hCAFEF00D;
        while (clear_busy && n < 100) begin
            step();
            n++;
        end
        wen = '0;
        chk("clr_cycles", 32'(n), 32'd32);
        for (int a = 0; a < 32; a++) begin
            raddr[4:0] = 5'(a); step();
            chk("clr_entry", rdata[31:0], 32'h0);
        end

        // 5: refill, scan with toggling ready
        rden = '0;
        for (int a = 0; a < 32; a++) begin
            waddr = 5'(a); wdata = 32'(a) * 32'h11111111; wen = 4'hF; step();
        end
        wen = '0; scan_start = 1'b1; step();
        scan_start = 1'b0;
        beats = 0; cyc = 0;
        while (beats < 32 && cyc < 200) begin
            scan_ready = (cyc % 2 == 0);
            chk("scan_valid", {31'b0, scan_valid}, 32'h1);
            chk("scan_addr", {27'b0, scan_addr}, 32'(beats));
            chk("scan_data", scan_data, 32'(beats) * 32'h11111111);
            chk("scan_nodone", {31'b0, scan_done}, 32'h0);
            if (scan_ready) beats++;
            cyc++;
            step();
        end
        scan_ready = 1'b0;
        chk("scan_beats", 32'(beats), 32'd32);
        chk("scan_done", {31'b0, scan_done}, 32'h1);
        chk("scan_end_valid", {31'b0, scan_valid}, 32'h0);
        step();
        chk("scan_done_pulse", {31'b0, scan_done}, 32'h0);

        // 6: clear aborts a scan at beat 10; scan_start ignored while busy
        scan_start = 1'b1; step();
        scan_start = 1'b0; scan_ready = 1'b1;
        cyc = 0;
        while (scan_addr != 5'd10 && cyc < 50) begin
            step();
            cyc++;
        end
        chk("abort_at10", {27'b0, scan_addr}, 32'd10);
        scan_ready = 1'b0; clear_req = 1'b1; step();
        clear_req = 1'b0;
        chk("abort_valid", {31'b0, scan_valid}, 32'h0);
        done_seen = scan_done;
        n = clear_busy ? 1 : 0;
        scan_start = 1'b1; step();
        scan_start = 1'b0;
        if (clear_busy) n++;
        done_seen |= scan_done;
        chk("start_ignored", {31'b0, scan_valid}, 32'h0);
        cyc = 0;
        while (clear_busy && cyc < 100) begin
            step();
            cyc++;
            if (clear_busy) n++;
            done_seen |= scan_done | scan_valid;
        end
        chk("abort_clr_cycles", 32'(n), 32'd32);
        chk("abort_no_done", {31'b0, done_seen}, 32'h0);
        rden = 2'b01; raddr[4:0] = 5'd17; step();
        chk("abort_cleared", rdata[31:0], 32'h0);

        // reset during clear
        rden = '0; waddr = 5'd30; wdata = 32'h0000ABCD; wen = 4'hF; step();
        wen = '0; rden = 2'b01; raddr[4:0] = 5'd30; step();
        chk("pre_rst_30", rdata[31:0], 32'h0000ABCD);
        clear_req = 1'b1; step();
        clear_req = 1'b0; step(); step();
        chk("mid_busy", {31'b0, clear_busy}, 32'h1);
        reset = 1'b1; step();
        reset = 1'b0;
        chk("rst_clr_busy", {31'b0, clear_busy}, 32'h0);
        chk("rst_clr_rdata", rdata[31:0], 32'h0);
        step();
        chk("rst_entry30", rdata[31:0], 32'h0);
        chk("rst_no_done", {31'b0, scan_done}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_bank_ctrl.md
Name: regfile_bank_ctrl

Overview:
Parametrised register file for the datapath test harnesses.
- Byte-lane write enables and NRD independently gated, registered read ports.
- Optional write-to-read bypass and hardwired-zero entry 0.
- Multi-cycle bulk-clear engine and a valid/ready scan streamer that walks every entry for the LCD display logic, replacing per-entry test-address polling.

Parameters:
DATA_W, 32, data width in bits; multiple of 8
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NRD, 2, number of read ports
ZERO_R0, 1, 1 = entry 0 reads as zero and ignores writes
BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
clk  in  1  clock
reset  in  1  reset; synchronous, active-high
wen  in  DATA_W/8  byte-lane write enables; bit i covers wdata[8i+7:8i]
waddr  in  ADDR_W  write address
wdata  in  DATA_W  write data
rden  in  NRD  per-port read enable
raddr  in  NRD*ADDR_W  read addresses; port k at [k*ADDR_W +: ADDR_W]
rdata  out  NRD*DATA_W  registered read data; port k at [k*DATA_W +: DATA_W]
clear_req  in  1  pulse: start bulk clear
clear_busy  out  1  high while the clear engine runs
scan_start  in  1  pulse: start scan of all entries
scan_valid  out  1  scan beat valid
scan_ready  in  1  consumer accepts beat
scan_addr  out  ADDR_W  address of current beat
scan_data  out  DATA_W  content of entry scan_addr
scan_done  out  1  one-cycle pulse after last beat accepted

Behaviour:
- Reset (sync, active-high): all entries 0, rdata 0, clear_busy 0, scan_valid 0, scan_addr 0, scan_done 0; both FSMs to IDLE. Reset mid-clear or mid-scan aborts with no scan_done.
- Write:
  - At posedge, for each wen[i]=1, byte i of entry waddr takes the wdata byte; other bytes hold.
  - wen=0 means no write.
  - Ignored when clear_busy=1 or when clear_req=1 in the same cycle.
  - Ignored for waddr=0 when ZERO_R0=1.
- Read:
  - Latency 1. rden[k]=1 loads rdata_k with entry raddr_k at the next edge; rden[k]=0 holds rdata_k.
  - BYPASS=1: if an accepted write hits raddr_k in the same cycle, enabled lanes take the new wdata bytes and disabled lanes take the old bytes.
  - BYPASS=0: rdata_k returns pre-write content.
  - ZERO_R0=1: raddr_k=0 always returns 0.
  - Ports are independent; equal addresses on several ports are legal.
- Clear FSM, states C_IDLE and C_RUN:
  - clear_req in C_IDLE: go to C_RUN, cnt=0.
  - In C_RUN: entry cnt written 0 each cycle and cnt increments. Exit to C_IDLE after writing DEPTH-1.
  - clear_busy = (state==C_RUN); exactly DEPTH cycles.
  - clear_req while busy is ignored. Reads are allowed during clear and return current array content.
- Scan FSM, states S_IDLE and S_RUN:
  - scan_start in S_IDLE, with clear_busy=0 and clear_req=0: go to S_RUN with scan_addr=0.
  - scan_valid = (state==S_RUN).
  - scan_data is combinational from entry scan_addr; it reflects writes immediately and ZERO_R0 applies.
  - scan_addr holds while scan_valid && !scan_ready.
  - On accept with scan_addr<DEPTH-1, scan_addr increments.
  - On accept at DEPTH-1: go to S_IDLE, scan_addr to 0, scan_done=1 next cycle for one cycle.
  - scan_start is ignored in S_RUN or while clearing.
  - clear_req during S_RUN aborts the scan: next cycle scan_valid=0, S_IDLE, no scan_done. Clear proceeds normally.
- Priority on the same edge: reset > clear_req > write > scan_start.

Test Plan:
1. Reset, write waddr=3 wdata=0x12345678 wen=4'hF, then rden[0]=1 raddr0=3 -> rdata0=0x12345678 one cycle later; write waddr=3 wdata=0xAABBCCDD wen=4'b0101 -> read returns 0x12BB56DD.
2. BYPASS=1: write waddr=7 wdata=0xDEADBEEF wen=4'hF while raddr1=7 rden[1]=1 in same cycle -> rdata1=0xDEADBEEF next cycle. BYPASS=0 -> old value 0. rden[1]=0 afterwards -> rdata1 holds.
3. ZERO_R0=1: write waddr=0 wdata=0xFFFFFFFF -> raddr0=0 reads 0 and scan beat 0 shows 0.
4. Fill entries with addr*0x11111111, pulse clear_req -> clear_busy high exactly 32 cycles; writes issued during busy are dropped; afterwards every entry reads 0.
5. Scan with scan_ready toggling 1,0,1,... -> 32 beats, addr 0..31 in order, each data = addr*0x11111111, scan_addr stable while not ready, single scan_done pulse after beat 31.
6. clear_req at beat 10 of a scan -> scan_valid low next cycle, no scan_done, clear completes in 32 cycles; scan_start during clear_busy ignored; reset during C_RUN -> clear_busy 0 next cycle and all entries 0.
